// File: rtl/uart_rx.sv
// uart_rx: 8N1-style serial receiver with an integrated receive FIFO.
//
// Ports:
//   clk            system clock, single domain
//   rst            synchronous active-high reset
//   rx             serial line, asynchronous to clk, idles high
//   rd_en          pop one FIFO entry when not empty
//   full / empty   FIFO occupancy flags, combinational from the pointers
//   d_out          last popped byte, registered, holds until the next pop
//   rx_error       1-cycle pulse on a bad stop bit
//   fifo_overflow  1-cycle pulse when a received byte is dropped (FIFO full)
//
// Build option: define UART_RX_SYNC_EN to pass rx through a 2-flop
// synchronizer; otherwise rx gets a single register stage.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | line idle, waiting for a sampled 1->0 transition
// S_START     | timing to mid start bit to confirm it is still low
// S_DATA      | sampling data bits at mid-bit, LSB first
// S_STOP      | sampling stop bit(s); deliver byte or flag framing error
// S_WAIT_IDLE | after a bad stop bit, wait for the line to return high

module uart_rx #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rd_en,
  output logic                 full,
  output logic                 empty,
  output logic [DATA_BITS-1:0] d_out,
  output logic                 rx_error,
  output logic                 fifo_overflow
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD;
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  // Input conditioning; flops reset high so reset never looks like a start edge.
  logic rx_s;
`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];
`else
  logic sync_q;
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 1'b1;
    else     sync_q <= rx;
  end
  assign rx_s = sync_q;
`endif

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_idx_q, bit_idx_d;
  logic                   stop_idx_q, stop_idx_d;
  logic                   stop_ok_q, stop_ok_d;
  logic                   rx_prev_q;
  logic [DATA_BITS-1:0]   rx_data, rx_data_d;
  logic                   rx_valid;
  logic                   frame_err;
  logic                   tick;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    stop_ok_d  = stop_ok_q;
    rx_data_d  = rx_data;
    rx_valid   = 1'b0;
    frame_err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_d                = '0;
          rx_data_d[bit_idx_q] = rx_s;
          if (bit_idx_q == BIT_LAST) begin
            state_d    = S_STOP;
            stop_idx_d = 1'b0;
            stop_ok_d  = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tick) begin
          cnt_d = '0;
          // Verdict is deferred to the last stop sample so both outcomes
          // land on the same edge regardless of STOP_BITS.
          if (stop_idx_q == STOP_LAST) begin
            if (stop_ok_q && rx_s) begin
              rx_valid = 1'b1;
              state_d  = S_IDLE;
            end else begin
              frame_err = 1'b1;
              state_d   = S_WAIT_IDLE;
            end
          end else begin
            stop_ok_d  = stop_ok_q & rx_s;
            stop_idx_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      stop_ok_q  <= 1'b0;
      rx_prev_q  <= 1'b1;
      rx_data    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      stop_ok_q  <= stop_ok_d;
      rx_prev_q  <= rx_s;
      rx_data    <= rx_data_d;
    end
  end

  // Receive FIFO; pointer MSB separates full from empty.
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_q, rd_ptr_q;
  logic [DATA_BITS-1:0] d_out_q;
  logic                 rx_error_q, fifo_overflow_q;
  logic                 do_wr, do_rd, overflow_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A read in the same cycle frees the slot, so a write at full is still taken.
  assign do_wr      = rx_valid && (!full || rd_en);
  assign do_rd      = rd_en && !empty;
  assign overflow_d = rx_valid && full && !rd_en;

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      d_out_q         <= '0;
      rx_error_q      <= 1'b0;
      fifo_overflow_q <= 1'b0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        d_out_q  <= mem_q[rd_ptr_q[AW-1:0]];
      end
      rx_error_q      <= frame_err;
      fifo_overflow_q <= overflow_d;
    end
  end

  assign d_out         = d_out_q;
  assign rx_error      = rx_error_q;
  assign fifo_overflow = fifo_overflow_q;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;
  // 1.6 MHz / 100 kbaud gives 16 clocks per bit; clock period 10 ns -> 160 ns bits.
  localparam int CLOCK_FREQ = 1_600_000;
  localparam int BAUD       = 100_000;
  localparam int DEPTH      = 16;
  localparam int BIT_NS     = 160;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic       full, empty, rx_error, fifo_overflow;
  logic [7:0] d_out;

  uart_rx #(
    .CLOCK_FREQ(CLOCK_FREQ), .BAUD(BAUD), .DATA_BITS(8),
    .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en),
    .full(full), .empty(empty), .d_out(d_out),
    .rx_error(rx_error), .fifo_overflow(fifo_overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int n_valid = 0, n_err = 0, n_ovf = 0;
  logic [7:0] sb_q[$];
  logic [7:0] model_q[$];

  // Monitor: every rx_valid pulse is checked against the scoreboard queue.
  always @(negedge clk) begin
    if (dut.rx_valid === 1'b1) begin
      n_valid++;
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL rx_valid_unexpected got=%02h exp=none", dut.rx_data);
      end else begin
        logic [7:0] e;
        e = sb_q.pop_front();
        if (dut.rx_data !== e) begin
          miscompares++;
          $display("FAIL rx_data got=%02h exp=%02h", dut.rx_data, e);
        end
      end
    end
    if (rx_error === 1'b1) n_err++;
    if (fifo_overflow === 1'b1) n_ovf++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int bit_ns,
                            input int gap_bits, input bit expect_valid);
    if (expect_valid) sb_q.push_back(b);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_val;
    #(bit_ns);
    rx = 1'b1;
    #(gap_bits * bit_ns);
  endtask

  int exp_ovf = 0;

  task automatic send_good(input logic [7:0] b, input int bit_ns, input int gap_bits);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else exp_ovf++;
    send_frame(b, 1'b1, bit_ns, gap_bits, 1'b1);
  endtask

  task automatic read_check(input string name);
    logic [7:0] e;
    @(negedge clk);
    rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    e = model_q.pop_front();
    check(name, d_out, e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hello [9];
    int v0, e0, o0;
    logic [7:0] head;
    bit found;
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h31, 8'h32, 8'h33};

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_dout", d_out, 0);
    check("rst_rx_error", rx_error, 0);
    check("rst_overflow", fifo_overflow, 0);
    check("rst_rx_data", dut.rx_data, 0);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);

    // "HELLO 123" at +1.9% bit time, 2-bit gap
    v0 = n_valid; e0 = n_err;
    for (int i = 0; i < 9; i++) send_good(hello[i], 163, 2);
    check("hello_valid_count", n_valid - v0, 9);
    check("hello_err_count", n_err - e0, 0);
    for (int i = 0; i < 9; i++) read_check("hello_read");
    check("hello_empty", empty, 1);

    // 19 x 0x41, zero gap, no reads -> overflow x3
    o0 = n_ovf;
    for (int i = 0; i < 19; i++) begin
      send_good(8'h41, BIT_NS, 0);
      check("fill_full", full, (i >= 15) ? 1 : 0);
    end
    #(2 * BIT_NS);
    check("ovf_count", n_ovf - o0, 3);
    check("ovf_count_model", n_ovf - o0, exp_ovf);
    for (int i = 0; i < 16; i++) read_check("ovf_read");
    check("ovf_empty", empty, 1);

    // Bad stop bit
    v0 = n_valid; e0 = n_err;
    send_frame(8'h42, 1'b0, BIT_NS, 2, 1'b0);
    check("ferr_count", n_err - e0, 1);
    check("ferr_valid", n_valid - v0, 0);
    check("ferr_empty", empty, 1);
    send_good(8'h37, BIT_NS, 2);
    read_check("after_ferr_read");

    // 0.3-bit glitch on idle line
    v0 = n_valid; e0 = n_err;
    rx = 1'b0;
    #48;
    rx = 1'b1;
    #(3 * BIT_NS);
    check("glitch_valid", n_valid - v0, 0);
    check("glitch_err", n_err - e0, 0);

    // Reset during a frame with 2 bytes queued
    send_good(8'h11, BIT_NS, 1);
    send_good(8'h22, BIT_NS, 1);
    check("pre_rst_empty", empty, 0);
    v0 = n_valid;
    fork
      send_frame(8'hFF, 1'b1, BIT_NS, 2, 1'b0);
      begin
        #(3 * BIT_NS);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
      end
    join
    model_q.delete();
    #1;
    check("midrst_empty", empty, 1);
    check("midrst_dout", d_out, 0);
    check("midrst_valid", n_valid - v0, 0);
    send_good(8'h5C, BIT_NS, 1);
    read_check("post_rst_read");

    // Read while empty: d_out and flags hold
    @(negedge clk) rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    check("empty_rd_dout", d_out, 8'h5C);
    check("empty_rd_empty", empty, 1);

    // Fill at -1.9% bit time, then simultaneous write + read at full
    for (int i = 0; i < 16; i++) send_good(8'h10 + 8'(i), 157, 0);
    check("refill_full", full, 1);
    o0 = n_ovf;
    head = model_q.pop_front();
    model_q.push_back(8'h5A);
    found = 1'b0;
    fork
      send_frame(8'h5A, 1'b1, 157, 1, 1'b1);
      begin
        for (int k = 0; k < 400 && !found; k++) begin
          @(negedge clk);
          if (dut.rx_valid === 1'b1) begin
            found = 1'b1;
            rd_en = 1'b1;
            @(posedge clk);
            #1 rd_en = 1'b0;
            check("simul_dout", d_out, head);
          end
        end
        if (!found) check("simul_timeout", 0, 1);
      end
    join
    check("simul_no_ovf", n_ovf - o0, 0);
    check("simul_full", full, 1);
    for (int i = 0; i < 16; i++) read_check("simul_drain");
    check("final_empty", empty, 1);
    check("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
